// File: rtl/ttt_pkg.sv
// Shared constants, FSM state type and line table for the tic-tac-toe auto player.
package ttt_pkg;

  localparam logic [1:0] GS_PLAY = 2'b00;
  localparam logic [1:0] GS_XWIN = 2'b01;
  localparam logic [1:0] GS_OWIN = 2'b10;
  localparam logic [1:0] GS_DRAW = 2'b11;

  localparam logic SYM_X = 1'b1;
  localparam logic SYM_O = 1'b0;

  typedef enum logic [2:0] {
    StWaitTurn,
    StThink,
    StScan,
    StIssue,
    StConfirm,
    StDone
  } state_e;

  // Cell indices of every line, in scan order: rows, cols, diagonal, anti-diagonal.
  localparam logic [3:0] LINE_TBL [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic game_over(input logic [1:0] gs);
    logic over;
    unique case (gs)
      GS_XWIN, GS_OWIN, GS_DRAW: over = 1'b1;
      default:                   over = 1'b0;
    endcase
    return over;
  endfunction

  function automatic logic [1:0] cell_row(input logic [3:0] c);
    logic [1:0] r;
    if (c < 4'd3)      r = 2'd0;
    else if (c < 4'd6) r = 2'd1;
    else               r = 2'd2;
    return r;
  endfunction

  function automatic logic [1:0] cell_col(input logic [3:0] c);
    logic [1:0] k;
    case (c)
      4'd0, 4'd3, 4'd6: k = 2'd0;
      4'd1, 4'd4, 4'd7: k = 2'd1;
      default:          k = 2'd2;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ttt_auto_player_if.sv
// Board move bus: board state towards the player, move strobe towards the board.
interface ttt_auto_player_if;
  logic [8:0] valid;
  logic [8:0] symbol;
  logic [1:0] game_state;
  logic       set;
  logic [1:0] row;
  logic [1:0] col;

  modport master (input valid, symbol, game_state, output set, row, col);
  modport slave  (output valid, symbol, game_state, input set, row, col);
endinterface

// File: rtl/ttt_pick.sv
// Combinational move chooser: win, block, centre, corners, edges.
module ttt_pick
  import ttt_pkg::*;
#(
  parameter bit AI_SYMBOL = SYM_O
) (
  input  logic [8:0] valid,
  input  logic [8:0] symbol,
  output logic [3:0] pick,
  output logic       pick_ok
);

  logic       win_found, blk_found;
  logic [3:0] win_cell, blk_cell;

  // Scan all lines; keep the first winning and first blocking empty cell.
  always_comb begin
    logic [1:0] own_cnt, opp_cnt, emp_cnt;
    logic [3:0] emp_cell, c;
    win_found = 1'b0;
    blk_found = 1'b0;
    win_cell  = '0;
    blk_cell  = '0;
    own_cnt   = '0;
    opp_cnt   = '0;
    emp_cnt   = '0;
    emp_cell  = '0;
    c         = '0;
    for (int l = 0; l < 8; l++) begin
      own_cnt  = '0;
      opp_cnt  = '0;
      emp_cnt  = '0;
      emp_cell = '0;
      for (int k = 0; k < 3; k++) begin
        c = LINE_TBL[l][k];
        if (!valid[c]) begin
          emp_cnt  = emp_cnt + 2'd1;
          emp_cell = c;
        end else if (symbol[c] == AI_SYMBOL) begin
          own_cnt = own_cnt + 2'd1;
        end else begin
          opp_cnt = opp_cnt + 2'd1;
        end
      end
      if (!win_found && own_cnt == 2'd2 && emp_cnt == 2'd1) begin
        win_found = 1'b1;
        win_cell  = emp_cell;
      end
      if (!blk_found && opp_cnt == 2'd2 && emp_cnt == 2'd1) begin
        blk_found = 1'b1;
        blk_cell  = emp_cell;
      end
    end
  end

  // Apply the priority order; pick_ok drops only on a full board.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b1;
    if (win_found)      pick = win_cell;
    else if (blk_found) pick = blk_cell;
    else if (!valid[4]) pick = 4'd4;
    else if (!valid[0]) pick = 4'd0;
    else if (!valid[2]) pick = 4'd2;
    else if (!valid[6]) pick = 4'd6;
    else if (!valid[8]) pick = 4'd8;
    else if (!valid[1]) pick = 4'd1;
    else if (!valid[3]) pick = 4'd3;
    else if (!valid[5]) pick = 4'd5;
    else if (!valid[7]) pick = 4'd7;
    else                pick_ok = 1'b0;
  end

endmodule

// File: rtl/ttt_auto_player.sv
// Automatic tic-tac-toe opponent: waits for its turn, thinks, picks, strobes, confirms.
module ttt_auto_player
  import ttt_pkg::*;
#(
  parameter bit          AI_SYMBOL    = SYM_O,
  parameter int unsigned THINK_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  ttt_auto_player_if.master board,
  output logic              busy,
  output logic              move_err,
  output logic [2:0]        moves_made
);

  state_e      state_q, state_d;
  logic [15:0] think_q, think_d;
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  pick_q, pick_d;
  logic [2:0]  moves_q, moves_d;
  logic        any_q;

  logic [3:0]  pick_c;
  logic        pick_ok;
  logic [3:0]  pop;
  logic        my_turn, turn_ok, board_cleared;
  logic        set_c, err_c;

  ttt_pick #(
    .AI_SYMBOL(AI_SYMBOL)
  ) u_pick (
    .valid  (board.valid),
    .symbol (board.symbol),
    .pick   (pick_c),
    .pick_ok(pick_ok)
  );

  assign pop     = popcount9(board.valid);
  assign my_turn = (pop[0] == 1'b0) == (AI_SYMBOL == SYM_X);
  assign turn_ok = my_turn && (pop < 4'd9);
  // Edge of the board going empty, so an X player can still open on an empty board.
  assign board_cleared = any_q && (board.valid == '0);

  // Next-state, counters and strobes; game over outranks everything else.
  always_comb begin
    state_d = state_q;
    think_d = think_q;
    tmo_d   = tmo_q;
    pick_d  = pick_q;
    moves_d = moves_q;
    set_c   = 1'b0;
    err_c   = 1'b0;
    if (game_over(board.game_state)) begin
      state_d = StDone;
    end else if (state_q == StDone) begin
      if (board.valid == '0) begin
        state_d = StWaitTurn;
        moves_d = '0;
      end
    end else if (board_cleared) begin
      state_d = StWaitTurn;
      moves_d = '0;
    end else begin
      unique case (state_q)
        StWaitTurn: begin
          if (enable && turn_ok) begin
            state_d = StThink;
            think_d = 16'(THINK_CYCLES - 1);
          end
        end
        StThink: begin
          if (!enable || !turn_ok)  state_d = StWaitTurn;
          else if (think_q == '0)   state_d = StScan;
          else                      think_d = think_q - 16'd1;
        end
        StScan: begin
          if (pick_ok) begin
            pick_d  = pick_c;
            state_d = StIssue;
          end else begin
            state_d = StWaitTurn;
          end
        end
        StIssue: begin
          // Cell filled since the scan: drop the move rather than strobe an occupied cell.
          if (board.valid[pick_q]) begin
            state_d = StWaitTurn;
          end else begin
            set_c   = 1'b1;
            state_d = StConfirm;
            tmo_d   = 16'(TIMEOUT - 1);
          end
        end
        StConfirm: begin
          if (board.valid[pick_q]) begin
            if (board.symbol[pick_q] == AI_SYMBOL && moves_q < 3'd5) moves_d = moves_q + 3'd1;
            state_d = StWaitTurn;
          end else if (tmo_q == '0) begin
            err_c   = 1'b1;
            state_d = StWaitTurn;
          end else begin
            tmo_d = tmo_q - 16'd1;
          end
        end
        StDone: ;
        default: state_d = StWaitTurn;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StWaitTurn;
      think_q <= '0;
      tmo_q   <= '0;
      pick_q  <= '0;
      moves_q <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      think_q <= think_d;
      tmo_q   <= tmo_d;
      pick_q  <= pick_d;
      moves_q <= moves_d;
      any_q   <= |board.valid;
    end
  end

  // Outputs: row/col follow the registered pick, which only changes on leaving SCAN.
  always_comb begin
    board.set  = set_c;
    board.row  = cell_row(pick_q);
    board.col  = cell_col(pick_q);
    busy       = state_q inside {StThink, StScan, StIssue, StConfirm};
    move_err   = err_c;
    moves_made = moves_q;
  end

endmodule

// File: tb/tb_ttt_auto_player.sv
// Directed bench for ttt_auto_player playing O with a small accepting board model.
module tb_ttt_auto_player;
  import ttt_pkg::*;

  localparam bit          AI    = SYM_O;
  localparam int unsigned THINK = 4;
  localparam int unsigned TMO   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       busy, move_err;
  logic [2:0] moves_made;
  logic       accept = 1'b1;

  int checks = 0;
  int failures = 0;
  int n, cnt, errs, first;

  ttt_auto_player_if bus();

  ttt_auto_player #(
    .AI_SYMBOL   (AI),
    .THINK_CYCLES(THINK),
    .TIMEOUT     (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .board     (bus),
    .busy      (busy),
    .move_err  (move_err),
    .moves_made(moves_made)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] valid;
    logic [8:0] symbol;
    int         row;
    int         col;
    string      name;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_board(input logic [8:0] v, input logic [8:0] s);
    bus.valid  = v;
    bus.symbol = s;
  endtask

  // Cycles from the board change (cycle 0) until set is seen; -1 if never.
  task automatic wait_set(output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.set === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Called at the negedge where set is high: check the cell, let the board take it.
  task automatic finish_move(input string tag, input int exp_moves);
    int idx;
    idx = int'(bus.row) * 3 + int'(bus.col);
    if (idx < 9) check({tag, "_cell_empty"}, int'(bus.valid[idx]), 0);
    @(posedge clk);
    #1;
    if (accept && idx < 9) begin
      bus.valid[idx]  = 1'b1;
      bus.symbol[idx] = AI;
    end
    @(negedge clk);
    check({tag, "_set_width"}, int'(bus.set), 0);
    @(negedge clk);
    check({tag, "_moves"}, int'(moves_made), exp_moves);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic clear_board(input string tag);
    @(posedge clk);
    #1;
    drive_board(9'h000, 9'h000);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_moves_cleared"}, int'(moves_made), 0);
  endtask

  initial begin
    vecs[0] = '{9'h001, 9'h001, 1, 1, "centre"};
    vecs[1] = '{9'h11B, 9'h103, 1, 2, "win_over_block"};
    vecs[2] = '{9'h013, 9'h003, 0, 2, "block_row"};
    vecs[3] = '{9'h010, 9'h010, 0, 0, "corner0"};
    vecs[4] = '{9'h111, 9'h011, 0, 2, "corner2"};
    vecs[5] = '{9'h155, 9'h111, 0, 1, "edge1"};
    vecs[6] = '{9'h01F, 9'h00D, 2, 1, "win_col"};
    vecs[7] = '{9'h0D5, 9'h0C1, 2, 2, "block_order"};

    drive_board(9'h000, 9'h000);
    bus.game_state = GS_PLAY;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_set", int'(bus.set), 0);
    check("rst_row", int'(bus.row), 0);
    check("rst_col", int'(bus.col), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_move_err", int'(move_err), 0);
    check("rst_moves", int'(moves_made), 0);

    // Empty board: X to move, so no activity.
    reset  = 1'b1;
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.set || busy) cnt++;
    end
    check("empty_board_idle", cnt, 0);

    // Pick table.
    for (int v = 0; v < 8; v++) begin
      @(posedge clk);
      #1;
      drive_board(vecs[v].valid, vecs[v].symbol);
      wait_set(n);
      check({vecs[v].name, "_latency"}, n, THINK + 2);
      check({vecs[v].name, "_row"}, int'(bus.row), vecs[v].row);
      check({vecs[v].name, "_col"}, int'(bus.col), vecs[v].col);
      finish_move(vecs[v].name, 1);
      clear_board(vecs[v].name);
    end

    // Board ignores the strobe: timeout, error pulse, retry of the same cell.
    accept = 1'b0;
    @(posedge clk);
    #1;
    drive_board(9'h001, 9'h001);
    wait_set(n);
    check("tmo_latency", n, THINK + 2);
    first = -1;
    errs  = 0;
    cnt   = 0;
    for (int i = 1; i <= int'(TMO) + 4; i++) begin
      @(negedge clk);
      if (bus.set) cnt++;
      if (move_err) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    check("tmo_err_delay", first, TMO);
    check("tmo_err_width", errs, 1);
    check("tmo_no_extra_set", cnt, 0);
    check("tmo_moves", int'(moves_made), 0);
    wait_set(n);
    check("retry_latency", n, 2);
    check("retry_row", int'(bus.row), 1);
    check("retry_col", int'(bus.col), 1);
    accept = 1'b1;
    finish_move("retry", 1);

    // Game ends during THINK: DONE until the board is reset.
    @(posedge clk);
    #1;
    drive_board(9'h111, 9'h101);
    @(negedge clk);
    @(negedge clk);
    check("gs_busy_think", int'(busy), 1);
    @(posedge clk);
    #1;
    bus.game_state = GS_XWIN;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.set) cnt++;
    end
    check("done_no_set", cnt, 0);
    check("done_busy", int'(busy), 0);
    check("done_moves_kept", int'(moves_made), 1);
    @(posedge clk);
    #1;
    bus.game_state = GS_PLAY;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.set || busy) cnt++;
    end
    check("done_holds_until_clear", cnt, 0);
    clear_board("done_exit");
    @(posedge clk);
    #1;
    drive_board(9'h001, 9'h001);
    wait_set(n);
    check("after_done_latency", n, THINK + 2);
    finish_move("after_done", 1);

    // Async reset mid-THINK clears outputs without waiting for a clock edge.
    @(posedge clk);
    #1;
    drive_board(9'h111, 9'h101);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_set", int'(bus.set), 0);
    check("async_moves", int'(moves_made), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
